hex_marquee_ctrl: RTL

//  Scroll sequencer for the 4-digit 7-seg bank (HEX3..HEX0, active-low segments).

---
 rtl/hex_marquee_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hex_marquee_ctrl.sv
// Scroll sequencer for a 4-digit active-low 7-seg bank.
// Steps a 4-character window across a message buffer on a prescaled tick.
module hex_marquee_ctrl #(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int MSG_LEN     = 8,
   parameter int AW          = $clog2(MSG_LEN),
   parameter int LW          = AW + 1
) (
   input  logic          CLOCK_50,
   input  logic          RESET,
   input  logic          start,
   input  logic          pause,
   input  logic          stop,
   input  logic          step_req,
   input  logic          dir,
   input  logic [1:0]    speed,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [6:0]    wr_data,
   input  logic          len_wr,
   input  logic [LW-1:0] len_data,
   output logic [6:0]    HEX3,
   output logic [6:0]    HEX2,
   output logic [6:0]    HEX1,
   output logic [6:0]    HEX0,
   output logic [7:0]    LEDG
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam int IW = AW + 2;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [LW-1:0]    len_q, len_d;
   logic [1:0]       speed_q;
   logic             step_q, step_d;
   logic [6:0]       buf_q [MSG_LEN];
   logic [6:0]       buf_d [MSG_LEN];
   logic [3:0][6:0]  hex_q, hex_d;
   logic [31:0]      period;
   logic             len_ok;
   logic [LW-1:0]    base, inc;

   always_comb begin
      period  = 32'(TICK_CYCLES) >> speed;
      len_ok  = len_wr && (len_data != '0) && (len_data <= LW'(MSG_LEN));
      len_d   = len_ok ? len_data : len_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (pause && state_q == S_RUN) begin
         state_d = S_PAUSE;
         cnt_d   = '0;
      end else if (start && state_q != S_RUN) begin
         state_d = S_RUN;
         cnt_d   = '0;
      end else if (step_req && state_q == S_PAUSE) begin
         step_d = 1'b1;
      end else if (state_q == S_RUN) begin
         if (speed != speed_q) begin
            cnt_d = '0;
         end else if (cnt_q == period - 32'd1) begin
            cnt_d  = '0;
            step_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   // Step is evaluated against the new length when one is loaded.
   always_comb begin
      base = ({1'b0, ptr_q} >= len_d) ? '0 : {1'b0, ptr_q};
      inc  = base + 1'b1;
      ptr_d = base[AW-1:0];
      if (stop) begin
         ptr_d = '0;
      end else if (step_d) begin
         if (dir) begin
            ptr_d = (base == '0) ? AW'(len_d - 1'b1) : AW'(base - 1'b1);
         end else begin
            ptr_d = (inc >= len_d) ? '0 : inc[AW-1:0];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < MSG_LEN; i++) begin
         buf_d[i] = buf_q[i];
      end
      if (wr_en) begin
         buf_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      logic [IW-1:0] idx;
      hex_d = hex_q;
      for (int i = 0; i < 4; i++) begin
         idx = IW'(ptr_q) + IW'(i);
         for (int k = 0; k < 4; k++) begin
            if (idx >= IW'(len_q)) begin
               idx = idx - IW'(len_q);
            end
         end
         hex_d[3-i] = buf_q[idx[AW-1:0]];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         len_q   <= LW'(4);
         speed_q <= '0;
         step_q  <= 1'b0;
         hex_q   <= {4{7'h7F}};
         for (int i = 0; i < MSG_LEN; i++) begin
            buf_q[i] <= 7'h7F;
         end
         buf_q[0] <= 7'h09;
         buf_q[1] <= 7'h06;
         buf_q[2] <= 7'h47;
         buf_q[3] <= 7'h0C;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         speed_q <= speed;
         step_q  <= step_d;
         hex_q   <= hex_d;
         for (int i = 0; i < MSG_LEN; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign HEX3 = hex_q[3];
   assign HEX2 = hex_q[2];
   assign HEX1 = hex_q[1];
   assign HEX0 = hex_q[0];
   assign LEDG = {step_q, 1'b0, state_q, 4'(ptr_q)};

endmodule
